// File: rtl/sc_speedtick_gen_if.sv
// sc_speedtick_gen_if: control inputs and status outputs of the speed tick
// generator, bundled so the board-level glue and the game logic share one view.
`timescale 1ns/1ps
interface sc_speedtick_gen_if #(
  parameter int SPEEDTICK_DATAWIDTH  = 28,
  parameter int SPEEDTICK_LEVELWIDTH = 2,
  parameter int SPEEDTICK_TALLYWIDTH = 8
);
  logic                            SC_SPEEDTICK_clear_InHigh;
  logic                            SC_SPEEDTICK_run_InLow;
  logic                            SC_SPEEDTICK_faster_InLow;
  logic                            SC_SPEEDTICK_slower_InLow;
  logic                            SC_SPEEDTICK_tick_Out;
  logic [SPEEDTICK_LEVELWIDTH-1:0] SC_SPEEDTICK_level_OutBUS;
  logic [SPEEDTICK_DATAWIDTH-1:0]  SC_SPEEDTICK_count_OutBUS;
  logic [SPEEDTICK_TALLYWIDTH-1:0] SC_SPEEDTICK_tally_OutBUS;

  // Side that drives the buttons and run/clear controls.
  modport master (
    output SC_SPEEDTICK_clear_InHigh, SC_SPEEDTICK_run_InLow,
           SC_SPEEDTICK_faster_InLow, SC_SPEEDTICK_slower_InLow,
    input  SC_SPEEDTICK_tick_Out, SC_SPEEDTICK_level_OutBUS,
           SC_SPEEDTICK_count_OutBUS, SC_SPEEDTICK_tally_OutBUS
  );

  // The tick generator itself.
  modport slave (
    input  SC_SPEEDTICK_clear_InHigh, SC_SPEEDTICK_run_InLow,
           SC_SPEEDTICK_faster_InLow, SC_SPEEDTICK_slower_InLow,
    output SC_SPEEDTICK_tick_Out, SC_SPEEDTICK_level_OutBUS,
           SC_SPEEDTICK_count_OutBUS, SC_SPEEDTICK_tally_OutBUS
  );
endinterface

// File: rtl/sc_speedtick_gen.sv
// sc_speedtick_gen: divides the 50 MHz clock by BASE >> level and emits a
// one-clock tick per period plus a wrapping tick tally. Two debounced
// active-low buttons step the speed level up/down with saturation.
`timescale 1ns/1ps
module sc_speedtick_gen #(
  parameter int SPEEDTICK_DATAWIDTH  = 28,
  parameter int SPEEDTICK_LEVELS     = 4,
  parameter int SPEEDTICK_LEVELWIDTH = 2,
  parameter int SPEEDTICK_BASE       = 25000000,
  parameter int SPEEDTICK_TALLYWIDTH = 8
)(
  input  logic              SC_SPEEDCOUNTER_CLOCK_50,
  input  logic              SC_SPEEDCOUNTER_RESET_InHigh,
  sc_speedtick_gen_if.slave bus
);
  localparam int DW = SPEEDTICK_DATAWIDTH;
  localparam int LW = SPEEDTICK_LEVELWIDTH;
  localparam int TW = SPEEDTICK_TALLYWIDTH;
  localparam logic [LW-1:0] LEVEL_MAX = LW'(SPEEDTICK_LEVELS - 1);
  localparam logic [DW-1:0] BASE_W    = DW'(SPEEDTICK_BASE);

  logic          faster_prev_r, slower_prev_r;
  logic          tick_r;
  logic [LW-1:0] level_r;
  logic [DW-1:0] count_r;
  logic [TW-1:0] tally_r;

  logic          faster_press_s, slower_press_s, level_chg_s, tick_nxt_s;
  logic [LW-1:0] level_nxt_s;
  logic [DW-1:0] count_nxt_s, period_m1_s;
  logic [TW-1:0] tally_nxt_s;

  // Press detection and saturating level stepping; a saturated or
  // simultaneous press produces no level change and hence no restart.
  always_comb begin
    faster_press_s = faster_prev_r & ~bus.SC_SPEEDTICK_faster_InLow;
    slower_press_s = slower_prev_r & ~bus.SC_SPEEDTICK_slower_InLow;
    level_nxt_s    = level_r;
    level_chg_s    = 1'b0;
    if (faster_press_s && !slower_press_s && (level_r != LEVEL_MAX)) begin
      level_nxt_s = level_r + LW'(1);
      level_chg_s = 1'b1;
    end else if (slower_press_s && !faster_press_s && (level_r != {LW{1'b0}})) begin
      level_nxt_s = level_r - LW'(1);
      level_chg_s = 1'b1;
    end else begin
      level_nxt_s = level_r;
      level_chg_s = 1'b0;
    end
  end

  // Divider next state: clear beats level restart beats pause beats counting.
  always_comb begin
    period_m1_s = (BASE_W >> level_r) - DW'(1);
    count_nxt_s = count_r;
    tally_nxt_s = tally_r;
    tick_nxt_s  = 1'b0;
    if (bus.SC_SPEEDTICK_clear_InHigh) begin
      count_nxt_s = {DW{1'b0}};
      tally_nxt_s = {TW{1'b0}};
      tick_nxt_s  = 1'b0;
    end else if (level_chg_s) begin
      count_nxt_s = {DW{1'b0}};
      tally_nxt_s = tally_r;
      tick_nxt_s  = 1'b0;
    end else if (bus.SC_SPEEDTICK_run_InLow) begin
      count_nxt_s = count_r;
      tally_nxt_s = tally_r;
      tick_nxt_s  = 1'b0;
    end else if (count_r == period_m1_s) begin
      count_nxt_s = {DW{1'b0}};
      tally_nxt_s = tally_r + TW'(1);
      tick_nxt_s  = 1'b1;
    end else begin
      count_nxt_s = count_r + DW'(1);
      tally_nxt_s = tally_r;
      tick_nxt_s  = 1'b0;
    end
  end

  // State registers; button history is sampled every clock unconditionally.
  always_ff @(posedge SC_SPEEDCOUNTER_CLOCK_50 or posedge SC_SPEEDCOUNTER_RESET_InHigh) begin
    if (SC_SPEEDCOUNTER_RESET_InHigh) begin
      faster_prev_r <= 1'b1;
      slower_prev_r <= 1'b1;
      tick_r        <= 1'b0;
      level_r       <= {LW{1'b0}};
      count_r       <= {DW{1'b0}};
      tally_r       <= {TW{1'b0}};
    end else begin
      faster_prev_r <= bus.SC_SPEEDTICK_faster_InLow;
      slower_prev_r <= bus.SC_SPEEDTICK_slower_InLow;
      tick_r        <= tick_nxt_s;
      level_r       <= level_nxt_s;
      count_r       <= count_nxt_s;
      tally_r       <= tally_nxt_s;
    end
  end

  assign bus.SC_SPEEDTICK_tick_Out     = tick_r;
  assign bus.SC_SPEEDTICK_level_OutBUS = level_r;
  assign bus.SC_SPEEDTICK_count_OutBUS = count_r;
  assign bus.SC_SPEEDTICK_tally_OutBUS = tally_r;
endmodule

// File: tb/tb_sc_speedtick_gen.sv
// tb_sc_speedtick_gen: directed stimulus with a tick scoreboard. Expected
// ticks (edge number, level, tally) are queued by the stimulus thread; a
// monitor pops one entry for every tick the DUT presents.
`timescale 1ns/1ps
module tb_sc_speedtick_gen;
  localparam int DW = 5;
  localparam int LV = 4;
  localparam int LW = 2;
  localparam int BASE = 16;
  localparam int TW = 3;

  typedef struct {
    int cyc;
    int level;
    int tally;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sc_speedtick_gen_if #(
    .SPEEDTICK_DATAWIDTH(DW), .SPEEDTICK_LEVELWIDTH(LW), .SPEEDTICK_TALLYWIDTH(TW)
  ) bus ();

  sc_speedtick_gen #(
    .SPEEDTICK_DATAWIDTH(DW), .SPEEDTICK_LEVELS(LV), .SPEEDTICK_LEVELWIDTH(LW),
    .SPEEDTICK_BASE(BASE), .SPEEDTICK_TALLYWIDTH(TW)
  ) dut (
    .SC_SPEEDCOUNTER_CLOCK_50(clk),
    .SC_SPEEDCOUNTER_RESET_InHigh(rst),
    .bus(bus)
  );

  // Rising edges since reset released: edge k leaves cyc == k.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic push(input int c, input int l, input int t);
    exp_t e;
    e.cyc = c; e.level = l; e.tally = t;
    exp_q.push_back(e);
  endtask

  // Called on a falling edge; returns on the falling edge after edge c.
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_state(input int l, input int c, input int t);
    check("level", int'(bus.SC_SPEEDTICK_level_OutBUS), l);
    check("count", int'(bus.SC_SPEEDTICK_count_OutBUS), c);
    check("tally", int'(bus.SC_SPEEDTICK_tally_OutBUS), t);
  endtask

  // Asserts reset between clock edges, checks outputs clear with no edge,
  // then releases on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    check("pending_ticks", exp_q.size(), 0);
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    check("reset_tick", int'(bus.SC_SPEEDTICK_tick_Out), 0);
    check_state(0, 0, 0);
    bus.SC_SPEEDTICK_clear_InHigh = 1'b0;
    bus.SC_SPEEDTICK_run_InLow    = 1'b0;
    bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    bus.SC_SPEEDTICK_slower_InLow = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every tick must match the head of the queue.
  initial begin
    logic prev_tick;
    exp_t e;
    prev_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SC_SPEEDTICK_tick_Out) begin
        check("tick_back_to_back", int'(prev_tick), 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tick at edge %0d: got a tick, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("tick_edge", cyc, e.cyc);
          check("tick_level", int'(bus.SC_SPEEDTICK_level_OutBUS), e.level);
          check("tick_tally", int'(bus.SC_SPEEDTICK_tally_OutBUS), e.tally);
        end
      end
      prev_tick = bus.SC_SPEEDTICK_tick_Out;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.SC_SPEEDTICK_clear_InHigh = 1'b0;
    bus.SC_SPEEDTICK_run_InLow    = 1'b0;
    bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    bus.SC_SPEEDTICK_slower_InLow = 1'b1;
    @(negedge clk);
    do_reset();

    // Free running at level 0: period 16.
    push(16, 0, 1); push(32, 0, 2); push(48, 0, 3);
    wait_to(48);

    // Three faster presses held 3 clocks each, then a saturated fourth.
    push(57, 2, 4); push(61, 2, 5);
    push(65, 3, 6); push(67, 3, 7); push(69, 3, 0); push(71, 3, 1);
    push(73, 3, 2); push(75, 3, 3);
    bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(49); check_state(1, 0, 3);
    wait_to(51); bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    wait_to(52); bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(53); check_state(2, 0, 3);
    wait_to(55); bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    wait_to(62); bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(63); check_state(3, 0, 5);
    wait_to(65); bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    wait_to(71); bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(72); check_state(3, 1, 1);
    wait_to(74); bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    wait_to(76);

    // Saturated slower at level 0, then simultaneous presses at level 2.
    do_reset();
    push(16, 0, 1); push(23, 2, 2); push(27, 2, 3);
    wait_to(4);  bus.SC_SPEEDTICK_slower_InLow = 1'b0;
    wait_to(5);  check_state(0, 5, 0);
    wait_to(7);  bus.SC_SPEEDTICK_slower_InLow = 1'b1;
    wait_to(16); bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(17); bus.SC_SPEEDTICK_faster_InLow = 1'b1; check_state(1, 0, 1);
    wait_to(18); bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(19); bus.SC_SPEEDTICK_faster_InLow = 1'b1; check_state(2, 0, 1);
    wait_to(21);
    bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    bus.SC_SPEEDTICK_slower_InLow = 1'b0;
    wait_to(22); check_state(2, 3, 1);
    bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    bus.SC_SPEEDTICK_slower_InLow = 1'b1;
    wait_to(28);

    // Pause at count 10 for 20 clocks, tally wrap, then clear at count 9.
    do_reset();
    for (int i = 0; i < 8; i++) push(36 + 16 * i, 0, (i + 1) % 8);
    push(174, 0, 1);
    wait_to(10); check_state(0, 10, 0);
    bus.SC_SPEEDTICK_run_InLow = 1'b1;
    wait_to(30); check_state(0, 10, 0);
    check("paused_tick", int'(bus.SC_SPEEDTICK_tick_Out), 0);
    bus.SC_SPEEDTICK_run_InLow = 1'b0;
    wait_to(157); check_state(0, 9, 0);
    bus.SC_SPEEDTICK_clear_InHigh = 1'b1;
    wait_to(158); check_state(0, 0, 0);
    bus.SC_SPEEDTICK_clear_InHigh = 1'b0;
    wait_to(175);

    // Reach level 2, count 3, tally 5, then reset asynchronously.
    do_reset();
    push(7, 2, 1); push(11, 2, 2); push(15, 2, 3); push(19, 2, 4); push(23, 2, 5);
    bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(1); bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    wait_to(2); bus.SC_SPEEDTICK_faster_InLow = 1'b0;
    wait_to(3); bus.SC_SPEEDTICK_faster_InLow = 1'b1;
    wait_to(26); check_state(2, 3, 5);
    do_reset();
    wait_to(3);

    check("final_pending_ticks", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
